// File: rtl/pc_source_reg.sv
// pc_source_reg
//
// Program-counter stage for the multicycle datapath. It selects the next PC
// from NUM_SRC packed candidates and holds it in an internal register. It also
// provides conditional (branch) writes, an optional word-alignment check, and a
// two-state RUN/TRAP sequencer that captures EPC and the fault cause.
//
// Ports:
//   clk            rising-edge clock for all state
//   reset          synchronous, active-high reset
//   sel            candidate index
//   src            packed candidates, source i at [i*WIDTH +: WIDTH]
//   pc_write       unconditional update request
//   pc_write_cond  branch update request, qualified by cond
//   cond           branch condition
//   exc_req        external exception request
//   pc             current PC register
//   next_pc        combinational src[sel], zero for an out-of-range sel
//   epc            PC captured at the last fault
//   cause          00 none, 01 external, 10 misaligned, 11 bad select
//   trap           high for the single TRAP-state cycle
//   busy           high in TRAP; update requests are ignored
module pc_source_reg #(
    parameter int                WIDTH        = 32,
    parameter int                NUM_SRC      = 8,
    parameter int                SEL_W        = 3,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'(32'h0000_00FC),
    parameter int                ALIGN_CHECK  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_SRC*WIDTH-1:0] src,
    input  logic                     pc_write,
    input  logic                     pc_write_cond,
    input  logic                     cond,
    input  logic                     exc_req,
    output logic [WIDTH-1:0]         pc,
    output logic [WIDTH-1:0]         next_pc,
    output logic [WIDTH-1:0]         epc,
    output logic [1:0]               cause,
    output logic                     trap,
    output logic                     busy
);

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    localparam logic [1:0] CAUSE_EXT   = 2'b01;
    localparam logic [1:0] CAUSE_ALIGN = 2'b10;
    localparam logic [1:0] CAUSE_SEL   = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [1:0]       cause_q, cause_d;
    logic             trap_q, trap_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] next_pc_w;
    logic             sel_valid;
    logic             upd;
    logic             misaligned;

    // Candidate mux. Select codes at or above NUM_SRC match no candidate and
    // therefore yield zero, which is also what the bad-select fault sees.
    always_comb begin
        next_pc_w = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                next_pc_w = src[i*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_valid  = (int'(sel) < NUM_SRC);
    assign upd        = pc_write | (pc_write_cond & cond);
    assign misaligned = (ALIGN_CHECK != 0) && (next_pc_w[1:0] != 2'b00);

    // Next-state logic. In RUN the fault priority is external exception, then
    // bad select, then misalignment. Select and alignment faults count only
    // when an update is actually requested. A fault holds pc for the TRAP
    // cycle. TRAP ignores every input, exc_req included, and loads the vector
    // on its way back to RUN.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        case (state_q)
            RUN: begin
                if (exc_req) begin
                    epc_d   = pc_q;
                    cause_d = CAUSE_EXT;
                    state_d = TRAP;
                end else if (upd && !sel_valid) begin
                    epc_d   = pc_q;
                    cause_d = CAUSE_SEL;
                    state_d = TRAP;
                end else if (upd && misaligned) begin
                    epc_d   = pc_q;
                    cause_d = CAUSE_ALIGN;
                    state_d = TRAP;
                end else if (upd) begin
                    pc_d = next_pc_w;
                end
            end
            TRAP: begin
                pc_d    = EXC_VECTOR;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        trap_d = (state_d == TRAP);
        busy_d = (state_d == TRAP);
    end

    // State register with synchronous reset. Reset overrides a pending vector
    // load, so a reset during TRAP returns directly to RUN at RESET_VECTOR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            cause_q <= 2'b00;
            trap_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            trap_q  <= trap_d;
            busy_q  <= busy_d;
        end
    end

    assign pc      = pc_q;
    assign next_pc = next_pc_w;
    assign epc     = epc_q;
    assign cause   = cause_q;
    assign trap    = trap_q;
    assign busy    = busy_q;

endmodule

// File: doc/pc_source_reg.md
# pc_source_reg

Parametrised program-counter stage for the multicycle datapath: selects the next PC from `NUM_SRC` candidate sources, holds it in an internal register, and adds conditional write, alignment checking and a two-state trap sequencer with EPC/cause capture. It sits between the PC-source candidates (ALU result, ALUOut, jump target, EPC, vectors) and the memory address mux, replacing the bare combinational PC-source mux plus external PC register.

## Interface
- `WIDTH`, 32, PC and source width in bits (≥ 8).
- `NUM_SRC`, 8, number of candidate sources (2..16).
- `SEL_W`, 3, select width; must satisfy 2^SEL_W ≥ NUM_SRC.
- `RESET_VECTOR`, 32'h0000_0000, PC value after reset.
- `EXC_VECTOR`, 32'h0000_00FC, PC value loaded on trap.
- `ALIGN_CHECK`, 1, 1 = candidate with `[1:0] != 0` raises a misalignment fault; 0 = no check.

- `clk`  in  1  clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sel`  in  SEL_W  source index.
- `src`  in  NUM_SRC*WIDTH  packed candidates; source i at `[i*WIDTH +: WIDTH]`.
- `pc_write`  in  1  unconditional PC update request.
- `pc_write_cond`  in  1  conditional update request (branch).
- `cond`  in  1  branch condition, qualifies `pc_write_cond`.
- `exc_req`  in  1  external exception request (overflow, illegal opcode).
- `pc`  out  WIDTH  current PC register.
- `next_pc`  out  WIDTH  combinational `src[sel]`; zero when `sel ≥ NUM_SRC`.
- `epc`  out  WIDTH  PC captured at last fault.
- `cause`  out  2  00 none, 01 external, 10 misaligned, 11 bad select.
- `trap`  out  1  high for exactly the TRAP-state cycle.
- `busy`  out  1  high in TRAP; update requests ignored.

## Operation
- States: RUN, TRAP. Reset → RUN.
- Reset values: `pc`=RESET_VECTOR, `epc`=0, `cause`=00, `trap`=0, `busy`=0.
- In RUN, `upd = pc_write | (pc_write_cond & cond)`.
- Priority per cycle in RUN: `exc_req` > bad select > misalignment > normal update.
  - `exc_req`: `epc`←`pc`, `cause`←01, → TRAP; `pc` holds.
  - `upd` with `sel ≥ NUM_SRC`: `epc`←`pc`, `cause`←11, → TRAP; `pc` holds.
  - `upd`, ALIGN_CHECK=1, `next_pc[1:0]≠0`: `epc`←`pc`, `cause`←10, → TRAP; `pc` holds.
  - `upd` otherwise: `pc`←`next_pc`.
  - no request: all state holds.
- Faults are checked only when `upd`=1 (except `exc_req`, always checked); invalid `sel` without `upd` is harmless.
- TRAP (one cycle): `trap`=1, `busy`=1; `pc`←EXC_VECTOR; all inputs ignored, including `exc_req`; → RUN.
- `cause` and `epc` hold until the next fault or reset; no software clear.
- `pc` wraps naturally at WIDTH bits; no overflow detection in this block.

## Timing
- Normal update: request in cycle N → new `pc` visible in cycle N+1 (one-cycle latency).
- Fault detected in cycle N → cycle N+1: state TRAP, `trap`=`busy`=1, `epc`/`cause` valid, `pc` unchanged → cycle N+2: `pc`=EXC_VECTOR, state RUN, accepts requests.
- Back-to-back updates accepted every RUN cycle.
- `exc_req` asserted during TRAP is dropped, not queued; the controller must hold it if it needs re-delivery.
- `reset` in any state, including mid-TRAP, wins: the next cycle shows reset values and RUN; a pending vector load is abandoned.
- `next_pc` is combinational from `sel`/`src`; every other output is registered.

## Test plan
- Reset then idle: `reset`=1 one cycle → `pc`=0, `epc`=0, `cause`=00, `trap`=0; 5 idle cycles → `pc` stays 0.
- Normal select: `src[3]`=32'h0000_0040, `sel`=3, `pc_write`=1 one cycle → next cycle `pc`=32'h40; repeat for all 8 indices with distinct aligned values.
- Branch: `pc_write_cond`=1, `cond`=0, `sel`=1, `src[1]`=32'h100 → `pc` unchanged; same with `cond`=1 → `pc`=32'h100.
- Misalignment: `pc`=32'h40, `src[2]`=32'h0000_0102, `sel`=2, `pc_write`=1 → N+1 `trap`=1, `cause`=10, `epc`=32'h40, `pc`=32'h40; N+2 `pc`=32'hFC, `trap`=0.
- Priority and drop: `exc_req`=1 with a valid `pc_write` in the same cycle → `cause`=01, `pc` not updated; `exc_req` held through TRAP → only one trap taken. NUM_SRC=5, `sel`=6, `pc_write`=1 → `cause`=11.
- Reset mid-trap: fault in cycle N, `reset`=1 in N+1 → N+2 `pc`=RESET_VECTOR, `cause`=00, `busy`=0, no vector load.
